// File: rtl/sd_card_multi_read_if.sv
// Bus bundle for the multi-block SD read engine: start/status, SD command
// handshake, SPI receive strobe and sector-buffer write port.
interface sd_card_multi_read_if #(
  parameter int CNT_W  = 8,
  parameter int BUF_AW = 12
);
  logic              i_start_read;
  logic [31:0]       i_addr;
  logic [CNT_W-1:0]  i_block_count;
  logic [7:0]        i_rx_byte;
  logic              i_rx_valid;
  logic              o_send_cmd;
  logic [3:0]        o_cmd_select;
  logic [31:0]       o_cmd_arg;
  logic              i_cmd_done;
  logic [7:0]        i_response_status;
  logic [7:0]        o_data;
  logic [BUF_AW-1:0] o_addr;
  logic              o_wr_nrd;
  logic              o_busy;
  logic              o_read_done;
  logic [7:0]        o_status;
  logic [7:0]        o_err_token;

  modport master (
    input  i_start_read, i_addr, i_block_count, i_rx_byte, i_rx_valid,
           i_cmd_done, i_response_status,
    output o_send_cmd, o_cmd_select, o_cmd_arg, o_data, o_addr, o_wr_nrd,
           o_busy, o_read_done, o_status, o_err_token
  );

  modport slave (
    output i_start_read, i_addr, i_block_count, i_rx_byte, i_rx_valid,
           i_cmd_done, i_response_status,
    input  o_send_cmd, o_cmd_select, o_cmd_arg, o_data, o_addr, o_wr_nrd,
           o_busy, o_read_done, o_status, o_err_token
  );
endinterface

// File: rtl/sd_card_multi_read.sv
// Multi-block SD read engine (CMD17 single, CMD18+CMD12 multi) writing into the sector buffer.
// Optional macro SD_READ_CRC16_EN enables CRC16-CCITT checking of each data block.
module sd_card_multi_read #(
  parameter int BLOCK_BYTES   = 512,
  parameter int CNT_W         = 8,
  parameter int BUF_AW        = 12,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input logic i_clk,
  input logic i_rst_n,
  sd_card_multi_read_if.master bus
);
  localparam int BW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] SEND_CMD   = 4'd1;
  localparam logic [3:0] WAIT_RSP   = 4'd2;
  localparam logic [3:0] WAIT_TOKEN = 4'd3;
  localparam logic [3:0] DATA       = 4'd4;
  localparam logic [3:0] CRC        = 4'd5;
  localparam logic [3:0] STOP       = 4'd6;
  localparam logic [3:0] STOP_RSP   = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  logic [3:0]        state;
  logic [31:0]       addr_lat;
  logic [CNT_W-1:0]  count_lat;
  logic [CNT_W-1:0]  block_idx;
  logic [BW-1:0]     byte_idx;
  logic [TW-1:0]     token_cnt;
  logic              crc_first;
  logic              multi;
  logic [7:0]        pend;
  logic [CNT_W+BW-1:0] full_addr;
  logic [3:0]        end_state;
  logic              crc_bad;

  assign full_addr = {block_idx, byte_idx};
  assign end_state = multi ? STOP : DONE;
  assign bus.o_busy = (state != IDLE);

`ifdef SD_READ_CRC16_EN
  logic [15:0] crc_acc;
  logic [7:0]  crc_hi;

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_bad = ({crc_hi, bus.i_rx_byte} != crc_acc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_acc <= '0;
      crc_hi  <= '0;
    end else begin
      if (state == WAIT_TOKEN) crc_acc <= '0;
      else if (state == DATA && bus.i_rx_valid) crc_acc <= crc16_next(crc_acc, bus.i_rx_byte);
      if (state == CRC && bus.i_rx_valid && crc_first) crc_hi <= bus.i_rx_byte;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Command pulses fire from SEND_CMD/STOP and appear while waiting for the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      addr_lat        <= '0;
      count_lat       <= '0;
      block_idx       <= '0;
      byte_idx        <= '0;
      token_cnt       <= '0;
      crc_first       <= 1'b0;
      multi           <= 1'b0;
      pend            <= '0;
      bus.o_send_cmd  <= 1'b0;
      bus.o_cmd_select <= '0;
      bus.o_cmd_arg   <= '0;
      bus.o_data      <= '0;
      bus.o_addr      <= '0;
      bus.o_wr_nrd    <= 1'b0;
      bus.o_read_done <= 1'b0;
      bus.o_status    <= '0;
      bus.o_err_token <= '0;
    end else begin
      bus.o_send_cmd  <= 1'b0;
      bus.o_wr_nrd    <= 1'b0;
      bus.o_read_done <= 1'b0;
      case (state)
        IDLE: if (bus.i_start_read) begin
          addr_lat        <= bus.i_addr;
          count_lat       <= bus.i_block_count;
          multi           <= (bus.i_block_count > CNT_W'(1));
          block_idx       <= '0;
          pend            <= '0;
          bus.o_status    <= '0;
          bus.o_err_token <= '0;
          state           <= (bus.i_block_count == '0) ? DONE : SEND_CMD;
        end
        SEND_CMD: begin
          bus.o_send_cmd   <= 1'b1;
          bus.o_cmd_select <= multi ? 4'd8 : 4'd3;
          bus.o_cmd_arg    <= addr_lat;
          state            <= WAIT_RSP;
        end
        WAIT_RSP: if (bus.i_cmd_done) begin
          bus.o_cmd_select <= '0;
          bus.o_cmd_arg    <= '0;
          token_cnt        <= '0;
          if (bus.i_response_status != 8'd1) begin
            pend  <= 8'd2;
            state <= DONE;
          end else begin
            state <= WAIT_TOKEN;
          end
        end
        WAIT_TOKEN: if (bus.i_rx_valid) begin
          if (bus.i_rx_byte == 8'hFE) begin
            byte_idx <= '0;
            state    <= DATA;
          end else if (bus.i_rx_byte[7:5] == 3'b000) begin
            bus.o_err_token <= bus.i_rx_byte;
            pend            <= 8'd3;
            state           <= end_state;
          end else if (token_cnt == TW'(TOKEN_TIMEOUT - 1)) begin
            pend  <= 8'd4;
            state <= end_state;
          end else begin
            token_cnt <= token_cnt + 1'b1;
          end
        end
        DATA: if (bus.i_rx_valid) begin
          bus.o_wr_nrd <= 1'b1;
          bus.o_data   <= bus.i_rx_byte;
          bus.o_addr   <= BUF_AW'(full_addr);
          byte_idx     <= byte_idx + 1'b1;
          if (byte_idx == BW'(BLOCK_BYTES - 1)) begin
            crc_first <= 1'b1;
            state     <= CRC;
          end
        end
        CRC: if (bus.i_rx_valid) begin
          if (crc_first) begin
            crc_first <= 1'b0;
          end else if (crc_bad) begin
            pend  <= 8'd5;
            state <= end_state;
          end else if (block_idx != count_lat - CNT_W'(1)) begin
            block_idx <= block_idx + 1'b1;
            token_cnt <= '0;
            state     <= WAIT_TOKEN;
          end else begin
            state <= end_state;
          end
        end
        STOP: begin
          bus.o_send_cmd   <= 1'b1;
          bus.o_cmd_select <= 4'd9;
          bus.o_cmd_arg    <= '0;
          state            <= STOP_RSP;
        end
        STOP_RSP: if (bus.i_cmd_done) begin
          bus.o_cmd_select <= '0;
          if (bus.i_response_status != 8'd1 && pend == '0) pend <= 8'd6;
          state <= DONE;
        end
        DONE: begin
          bus.o_read_done <= 1'b1;
          bus.o_status    <= (pend == '0) ? 8'd1 : pend;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_card_multi_read.sv
// Scoreboard bench for sd_card_multi_read: expected writes and commands are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_sd_card_multi_read;
  localparam int BB = 512;

  logic clk;
  logic rst_n;
  int testsRun;
  int failCount;
  int doneCount;
  int doneBase;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wrQ[$];
  logic [35:0] cmdQ[$];

  sd_card_multi_read_if #(.CNT_W(8), .BUF_AW(12)) bus();

  sd_card_multi_read #(
    .BLOCK_BYTES(BB), .CNT_W(8), .BUF_AW(12), .TOKEN_TIMEOUT(4096)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] crc16Model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Monitors sample at the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n && bus.o_wr_nrd) begin
      if (wrQ.size() == 0) checkOutput("unexp_wr", 1, 0);
      else begin
        wr_t e;
        e = wrQ.pop_front();
        checkOutput("wr_addr", 32'(bus.o_addr), 32'(e.a));
        checkOutput("wr_data", 32'(bus.o_data), 32'(e.d));
      end
    end
    if (rst_n && bus.o_send_cmd) begin
      if (cmdQ.size() == 0) checkOutput("unexp_cmd", 1, 0);
      else begin
        logic [35:0] c;
        c = cmdQ.pop_front();
        checkOutput("cmd_select", 32'(bus.o_cmd_select), 32'(c[35:32]));
        checkOutput("cmd_arg", bus.o_cmd_arg, c[31:0]);
      end
    end
    if (rst_n && bus.o_read_done) doneCount++;
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] count);
    doneBase = doneCount;
    bus.i_addr = addr;
    bus.i_block_count = count;
    bus.i_start_read = 1'b1;
    @(posedge clk); #1;
    bus.i_start_read = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.i_rx_byte = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic respondCmd(input logic [3:0] sel, input logic [31:0] arg, input logic [7:0] resp);
    bit seen;
    cmdQ.push_back({sel, arg});
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_send_cmd) seen = 1'b1;
    end
    if (!seen) checkOutput("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    bus.i_response_status = resp;
    bus.i_cmd_done = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_done = 1'b0;
  endtask

  task automatic sendBlock(input int blk, input int mul, input int base,
                           input bit forceCrc, input logic [15:0] crcValue);
    logic [15:0] crc;
    logic [7:0] d;
    crc = 16'h0000;
    sendByte(8'hFE);
    for (int n = 0; n < BB; n++) begin
      d = 8'(n * mul + base);
      wrQ.push_back('{a: 12'(blk * BB + n), d: d});
      sendByte(d);
      crc = crc16Model(crc, d);
    end
    if (forceCrc) crc = crcValue;
    sendByte(crc[15:8]);
    sendByte(crc[7:0]);
  endtask

  task automatic waitDone(input logic [7:0] expStatus, input logic [7:0] expTok);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_read_done) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    checkOutput("status", 32'(bus.o_status), 32'(expStatus));
    checkOutput("err_token", 32'(bus.o_err_token), 32'(expTok));
    checkOutput("busy_at_done", 32'(bus.o_busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic endTest(input int expDone);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("done_pulses", doneCount - doneBase, expDone);
    checkOutput("wrq_left", wrQ.size(), 0);
    checkOutput("cmdq_left", cmdQ.size(), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0;
    failCount = 0;
    doneCount = 0;
    doneBase = 0;
    rst_n = 1'b0;
    bus.i_start_read = 1'b0;
    bus.i_addr = '0;
    bus.i_block_count = '0;
    bus.i_rx_byte = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_cmd_done = 1'b0;
    bus.i_response_status = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.o_busy), 0);
    checkOutput("rst_status", 32'(bus.o_status), 0);
    checkOutput("rst_cmd_select", 32'(bus.o_cmd_select), 0);
    checkOutput("rst_send_cmd", 32'(bus.o_send_cmd), 0);
    checkOutput("rst_wr", 32'(bus.o_wr_nrd), 0);
    checkOutput("rst_done", 32'(bus.o_read_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single block CMD17");
    applyStimulus(32'h100, 8'd1);
    respondCmd(4'd3, 32'h100, 8'd1);
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendBlock(0, 1, 0, 1'b0, 16'h0);
    waitDone(8'd1, 8'd0);
    endTest(1);

    $display("[TB] three blocks CMD18 + CMD12");
    applyStimulus(32'h20, 8'd3);
    respondCmd(4'd8, 32'h20, 8'd1);
    for (int b = 0; b < 3; b++) begin
      sendByte(8'hFF);
      sendBlock(b, 3, b * 7, 1'b0, 16'h0);
    end
    respondCmd(4'd9, 32'h0, 8'd1);
    waitDone(8'd1, 8'd0);
    endTest(1);

    $display("[TB] command response error");
    applyStimulus(32'h55, 8'd2);
    respondCmd(4'd8, 32'h55, 8'h04);
    waitDone(8'd2, 8'd0);
    endTest(1);

    $display("[TB] data error token on second block");
    applyStimulus(32'h400, 8'd2);
    respondCmd(4'd8, 32'h400, 8'd1);
    sendBlock(0, 5, 1, 1'b0, 16'h0);
    sendByte(8'hFF);
    sendByte(8'h08);
    respondCmd(4'd9, 32'h0, 8'd1);
    waitDone(8'd3, 8'h08);
    endTest(1);

    $display("[TB] CMD12 response error");
    applyStimulus(32'h800, 8'd2);
    respondCmd(4'd8, 32'h800, 8'd1);
    sendBlock(0, 1, 9, 1'b0, 16'h0);
    sendBlock(1, 2, 3, 1'b0, 16'h0);
    respondCmd(4'd9, 32'h0, 8'h05);
    waitDone(8'd6, 8'd0);
    endTest(1);

    $display("[TB] token timeout");
    applyStimulus(32'h77, 8'd1);
    respondCmd(4'd3, 32'h77, 8'd1);
    for (int i = 0; i < 4095; i++) sendByte(8'hFF);
    repeat (2) @(negedge clk);
    checkOutput("no_early_timeout", doneCount - doneBase, 0);
    checkOutput("busy_before_timeout", 32'(bus.o_busy), 1);
    @(posedge clk); #1;
    sendByte(8'hFF);
    waitDone(8'd4, 8'd0);
    endTest(1);

    $display("[TB] zero block count");
    applyStimulus(32'h9, 8'd0);
    waitDone(8'd1, 8'd0);
    endTest(1);

`ifdef SD_READ_CRC16_EN
    $display("[TB] CRC good and bad");
    applyStimulus(32'h1, 8'd1);
    respondCmd(4'd3, 32'h1, 8'd1);
    sendBlock(0, 0, 0, 1'b1, 16'h0000);
    waitDone(8'd1, 8'd0);
    endTest(1);
    applyStimulus(32'h2, 8'd1);
    respondCmd(4'd3, 32'h2, 8'd1);
    sendBlock(0, 0, 0, 1'b1, 16'h1234);
    waitDone(8'd5, 8'd0);
    endTest(1);
`else
    $display("[TB] CRC bytes discarded");
    applyStimulus(32'h2, 8'd1);
    respondCmd(4'd3, 32'h2, 8'd1);
    sendBlock(0, 0, 0, 1'b1, 16'h1234);
    waitDone(8'd1, 8'd0);
    endTest(1);
`endif

    $display("[TB] reset during data phase");
    applyStimulus(32'h300, 8'd1);
    doneBase = doneCount;
    respondCmd(4'd3, 32'h300, 8'd1);
    sendByte(8'hFE);
    for (int n = 0; n < 100; n++) begin
      wrQ.push_back('{a: 12'(n), d: 8'(n + 8'h40)});
      sendByte(8'(n + 8'h40));
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(bus.o_busy), 0);
    checkOutput("mid_rst_wr", 32'(bus.o_wr_nrd), 0);
    checkOutput("mid_rst_data", 32'(bus.o_data), 0);
    checkOutput("mid_rst_addr", 32'(bus.o_addr), 0);
    checkOutput("mid_rst_status", 32'(bus.o_status), 0);
    checkOutput("mid_rst_cmd_select", 32'(bus.o_cmd_select), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) sendByte(8'h11);
    endTest(0);
    checkOutput("post_rst_busy", 32'(bus.o_busy), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
